// File: rtl/fa_cache_lease_table_loader.sv
// Lease table image loader for the fully-associative lease cache.
// Turns a word stream into config and LLT writes for the policy controller.
module fa_cache_lease_table_loader #(
    parameter int N_ENTRIES     = 128,
    parameter int BW_LEASE      = 24,
    parameter int BW_PERCENTAGE = 9,
    localparam int BW_ENTRIES    = $clog2(N_ENTRIES),
    localparam int BW_ADDR_SPACE = BW_ENTRIES + 2
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic                     start_i,
    input  logic [31:0]              data_i,
    input  logic                     data_valid_i,
    output logic                     data_ready_o,
    output logic                     con_wren_o,
    output logic                     llt_wren_o,
    output logic [BW_ADDR_SPACE-1:0] llt_addr_o,
    output logic [31:0]              llt_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [BW_ENTRIES:0]      entries_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_COUNT,
        S_ENTRY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                   state_q, state_d;
    logic [BW_ENTRIES-1:0]    idx_q, idx_d;
    logic [1:0]               field_q, field_d;
    logic [BW_ENTRIES:0]      n_q, n_d;
    logic                     con_wren_q, con_wren_d;
    logic                     llt_wren_q, llt_wren_d;
    logic [BW_ADDR_SPACE-1:0] llt_addr_q, llt_addr_d;
    logic [31:0]              llt_data_q, llt_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [BW_ENTRIES:0]      entries_q, entries_d;

    logic        accept;
    logic        last_entry;
    logic [31:0] lease_ext;
    logic [31:0] prob_ext;
    logic [31:0] entry_data;

    assign data_ready_o = (state_q == S_CFG) ||
                          (state_q == S_COUNT) ||
                          (state_q == S_ENTRY);
    assign accept = data_valid_i && data_ready_o;

    assign lease_ext = {{(32-BW_LEASE){1'b0}}, data_i[BW_LEASE-1:0]};
    assign prob_ext  = {{(32-BW_PERCENTAGE){1'b0}},
                        data_i[BW_PERCENTAGE-1:0]};

    assign last_entry = ({1'b0, idx_q} ==
                         (n_q - (BW_ENTRIES+1)'(1)));

    // Field 0 is a full address; leases and prob drop unused high bits.
    always_comb begin
        entry_data = lease_ext;
        unique case (field_q)
            2'd0:    entry_data = data_i;
            2'd3:    entry_data = prob_ext;
            default: entry_data = lease_ext;
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        field_d    = field_q;
        n_d        = n_q;
        con_wren_d = 1'b0;
        llt_wren_d = 1'b0;
        llt_addr_d = llt_addr_q;
        llt_data_d = llt_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        entries_d  = entries_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_CFG;
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    entries_d = '0;
                end
            end
            S_CFG: begin
                if (accept) begin
                    con_wren_d = 1'b1;
                    llt_addr_d = '0;
                    llt_data_d = lease_ext;
                    state_d    = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    n_d = data_i[BW_ENTRIES:0];
                    if (data_i == 32'd0) begin
                        state_d = S_DONE;
                    end else if (data_i > 32'(N_ENTRIES)) begin
                        state_d = S_ERROR;
                    end else begin
                        idx_d   = '0;
                        field_d = '0;
                        state_d = S_ENTRY;
                    end
                end
            end
            S_ENTRY: begin
                if (accept) begin
                    llt_wren_d = 1'b1;
                    llt_addr_d = {field_q, idx_q};
                    llt_data_d = entry_data;
                    field_d    = field_q + 2'd1;
                    if (field_q == 2'd3) begin
                        idx_d     = idx_q + BW_ENTRIES'(1);
                        entries_d = entries_q + (BW_ENTRIES+1)'(1);
                        if (last_entry) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                error_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered write port.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            field_q    <= '0;
            n_q        <= '0;
            con_wren_q <= 1'b0;
            llt_wren_q <= 1'b0;
            llt_addr_q <= '0;
            llt_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            entries_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            field_q    <= field_d;
            n_q        <= n_d;
            con_wren_q <= con_wren_d;
            llt_wren_q <= llt_wren_d;
            llt_addr_q <= llt_addr_d;
            llt_data_q <= llt_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            entries_q  <= entries_d;
        end
    end

    assign con_wren_o       = con_wren_q;
    assign llt_wren_o       = llt_wren_q;
    assign llt_addr_o       = llt_addr_q;
    assign llt_data_o       = llt_data_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign entries_loaded_o = entries_q;

endmodule
